// File: rtl/register_writeback_pkg.sv
// Shared constants and types for the register bank and its write-side sequencer.
package register_writeback_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    // One queued memory result; live is cleared when a younger write supersedes it.
    typedef struct packed {
        logic              live;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry;

endpackage

// File: rtl/wb_fifo.sv
// Queue of pending memory load results with per-entry live bits, squash-by-dest,
// flush, and a per-register busy mask derived from the live occupied entries.
module wb_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = register_writeback_pkg::DATA_W,
    parameter int ADDR_W = register_writeback_pkg::ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      push,
    input  logic [ADDR_W-1:0]         push_dest,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    input  logic                      squash,
    input  logic [ADDR_W-1:0]         squash_dest,
    input  logic                      flush,
    output logic                      head_live,
    output logic [ADDR_W-1:0]         head_dest,
    output logic [DATA_W-1:0]         head_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic [2**ADDR_W-1:0]      busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [DEPTH-1:0]  live;
    logic [ADDR_W-1:0] dest_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            live   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            live   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash && dest_mem[i] == squash_dest) begin
                    live[i] <= 1'b0;
                end
            end
            if (pop) begin
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                live[wr_ptr] <= 1'b1;
                wr_ptr       <= wr_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: payload storage is not reset; occupancy is defined solely by the
    // pointers, count and live bits, which are.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_mem[wr_ptr] <= push_dest;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign head_live = live[rd_ptr];
    assign head_dest = dest_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    always_comb begin
        // NOTE: default assigned before the loop so no bit of busy can infer a latch.
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] offs;
            offs = PTR_W'(i) - rd_ptr;
            if (live[i] && ({1'b0, offs} < count)) begin
                busy[dest_mem[i]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/register_writeback.sv
// Write-port sequencer: ALU results take priority, memory results bypass when the
// queue is empty or wait in wb_fifo; write-port outputs are registered.
module register_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = register_writeback_pkg::DATA_W,
    parameter int ADDR_W = register_writeback_pkg::ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 alu_valid,
    input  logic [ADDR_W-1:0]    alu_dest,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    input  logic [ADDR_W-1:0]    mem_dest,
    input  logic [DATA_W-1:0]    mem_data,
    output logic                 mem_ready,
    input  logic                 flush,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic [2**ADDR_W-1:0] busy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]  count;
    logic              head_live;
    logic [ADDR_W-1:0] head_dest;
    logic [DATA_W-1:0] head_data;

    logic              fifo_empty;
    logic              mem_xfer;
    logic              same_dest;
    logic              do_pop;
    logic              do_bypass;
    logic              do_push;
    logic              nxt_en;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] nxt_data;

    // Depends only on registered occupancy so the memory side never sees an ALU path.
    assign mem_ready = (count < CNT_W'(DEPTH));

    always_comb begin
        fifo_empty = (count == '0);
        mem_xfer   = mem_valid && mem_ready;
        same_dest  = alu_valid && (alu_dest == mem_dest);
        do_pop     = !alu_valid && !fifo_empty;
        do_bypass  = !alu_valid && fifo_empty && mem_xfer;
        // The load is older than a same-cycle ALU write to its register, so it is dropped.
        do_push    = mem_xfer && !do_bypass && !same_dest && !flush;

        nxt_en   = 1'b0;
        nxt_addr = wr_addr;
        nxt_data = wr_data;
        if (alu_valid) begin
            nxt_en   = 1'b1;
            nxt_addr = alu_dest;
            nxt_data = alu_data;
        end else if (do_pop) begin
            if (head_live && !flush) begin
                nxt_en   = 1'b1;
                nxt_addr = head_dest;
                nxt_data = head_data;
            end
        end else if (do_bypass && !flush) begin
            nxt_en   = 1'b1;
            nxt_addr = mem_dest;
            nxt_data = mem_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en   <= nxt_en;
            wr_addr <= nxt_addr;
            wr_data <= nxt_data;
        end
    end

    wb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (do_push),
        .push_dest   (mem_dest),
        .push_data   (mem_data),
        .pop         (do_pop),
        .squash      (alu_valid),
        .squash_dest (alu_dest),
        .flush       (flush),
        .head_live   (head_live),
        .head_dest   (head_dest),
        .head_data   (head_data),
        .count       (count),
        .busy        (busy)
    );

endmodule
